// File: rtl/bus_split_bank.sv
// Bank of NCHAN split registers on the local register bus. A read returns a
// hardware input and a write drives a held output, with optional coherent modes.

module bus_split_chan #(
  parameter int            DW        = 32,
  parameter logic [DW-1:0] IZ        = '0,
  parameter bit            HAS_STAGE = 1'b0,
  parameter bit            HAS_SNAP  = 1'b0
) (
  input  logic          bus_clk,
  input  logic          bus_reset,
  input  logic          ld,
  input  logic          st_ld,
  input  logic          snap_ld,
  input  logic [DW-1:0] wr_val,
  input  logic [DW-1:0] in_val,
  output logic [DW-1:0] out_val,
  output logic [DW-1:0] rd_val,
  output logic          pulse
);

  logic [DW-1:0] ld_val;

  // A staged channel takes its committed value from the stage, not from the bus.
  generate
    if (HAS_STAGE) begin : g_stage
      logic [DW-1:0] stage;
      always_ff @(posedge bus_clk) begin
        if (bus_reset)  stage <= IZ;
        else if (st_ld) stage <= wr_val;
      end
      assign ld_val = stage;
    end else begin : g_direct
      logic unused_st;
      assign unused_st = st_ld;
      assign ld_val    = wr_val;
    end

    if (HAS_SNAP) begin : g_snap
      logic [DW-1:0] snap;
      always_ff @(posedge bus_clk) begin
        if (bus_reset)    snap <= '0;
        else if (snap_ld) snap <= in_val;
      end
      assign rd_val = snap;
    end else begin : g_live
      logic unused_snap;
      assign unused_snap = snap_ld;
      assign rd_val      = in_val;
    end
  endgenerate

  always_ff @(posedge bus_clk) begin
    if (bus_reset) begin
      out_val <= IZ;
      pulse   <= 1'b0;
    end else begin
      pulse <= ld;
      if (ld) out_val <= ld_val;
    end
  end

endmodule

module bus_split_bank #(
  parameter int          DATAWIDTH = 32,
  parameter int          OFFSET    = 0,
  parameter int          NCHAN     = 2,
  parameter logic [31:0] ADDR      = 32'h0,
  parameter logic [31:0] IZ        = 32'h0,
  parameter int          ATOMIC_RD = 0,
  parameter int          ATOMIC_WR = 0,
  parameter int          REG       = 1,
  parameter int          SIZE      = 4*NCHAN,
  localparam int         BUS_IN_WIDTH  = 66,
  localparam int         BUS_OUT_WIDTH = 35
) (
  input  logic                       bus_clk,
  input  logic                       bus_reset,
  input  logic [BUS_IN_WIDTH-1:0]    bus_in,
  output logic [BUS_OUT_WIDTH-1:0]   bus_out,
  input  logic [NCHAN*DATAWIDTH-1:0] in,
  output logic [NCHAN*DATAWIDTH-1:0] out,
  output logic [NCHAN-1:0]           wr_pulse,
  output logic                       commit_pulse
);

  // bus_in = {we, re, addr[31:0], wr_data[31:0]}; bus_out = {irq, wr_ack, rd_ack, rd_data}
  logic [31:0] wr_data, addr, addr_w, rd_data;
  logic        re, we, rd_ack, wr_ack, commit;
  logic [NCHAN-1:0] hit, ld;
  logic [NCHAN-1:0][DATAWIDTH-1:0] out_val, rd_val;
  logic [DATAWIDTH-1:0] wr_val, rd_sel;

  assign wr_data = bus_in[31:0];
  assign addr    = bus_in[63:32];
  assign re      = bus_in[64];
  assign we      = bus_in[65];
  assign addr_w  = {addr[31:2], 2'b00};
  assign wr_val  = DATAWIDTH'(wr_data >> OFFSET);

  logic unused_cfg;
  assign unused_cfg = &{1'b0, addr[1:0], REG[0], SIZE[0]};

  // In atomic-write mode only the last channel's write moves any output.
  assign commit = (ATOMIC_WR != 0) && we && hit[NCHAN-1];

  genvar k;
  generate
    for (k = 0; k < NCHAN; k++) begin : g_chan
      assign hit[k] = (addr_w == ADDR + 32'(4*k));
      assign ld[k]  = (ATOMIC_WR != 0) ? commit : (we & hit[k]);

      bus_split_chan #(
        .DW        (DATAWIDTH),
        .IZ        (IZ[DATAWIDTH-1:0]),
        .HAS_STAGE ((ATOMIC_WR != 0) && (k < NCHAN-1)),
        .HAS_SNAP  ((ATOMIC_RD != 0) && (k >= 1))
      ) u_chan (
        .bus_clk   (bus_clk),
        .bus_reset (bus_reset),
        .ld        (ld[k]),
        .st_ld     (we & hit[k]),
        .snap_ld   (re & hit[0]),
        .wr_val    (wr_val),
        .in_val    (in[k*DATAWIDTH +: DATAWIDTH]),
        .out_val   (out_val[k]),
        .rd_val    (rd_val[k]),
        .pulse     (wr_pulse[k])
      );

      assign out[k*DATAWIDTH +: DATAWIDTH] = out_val[k];
    end
  endgenerate

  always_comb begin
    rd_sel = '0;
    for (int i = 0; i < NCHAN; i++)
      if (hit[i]) rd_sel = rd_sel | rd_val[i];
  end

  assign rd_ack  = re & (|hit);
  assign wr_ack  = we & (|hit);
  assign rd_data = rd_ack ? (32'(rd_sel) << OFFSET) : 32'h0;
  assign bus_out = {1'b0, wr_ack, rd_ack, rd_data};

  always_ff @(posedge bus_clk) begin
    if (bus_reset) commit_pulse <= 1'b0;
    else           commit_pulse <= commit;
  end

endmodule

// File: tb/tb_bus_split_bank.sv
// Three bank configurations share one bus; a table-driven reference model
// predicts reads, acks, outputs and pulses for random and directed traffic.

module tb_bus_split_bank;

  localparam int          NI = 3;
  localparam int          P_DW  [NI] = '{8, 32, 16};
  localparam int          P_OFF [NI] = '{8, 0, 4};
  localparam int          P_N   [NI] = '{2, 2, 3};
  localparam logic [31:0] P_BASE[NI] = '{32'h40, 32'h80, 32'h100};
  localparam logic [31:0] P_IZ  [NI] = '{32'h5A, 32'h0, 32'h5A};
  localparam bit          P_ARD [NI] = '{1'b0, 1'b1, 1'b1};
  localparam bit          P_AWR [NI] = '{1'b0, 1'b0, 1'b1};

  logic        bus_clk = 1'b0;
  logic        bus_reset = 1'b0;
  logic [65:0] bus_in = '0;
  logic [34:0] bo_a, bo_b, bo_c;
  logic [15:0] in_a = '0, out_a;
  logic [63:0] in_b = '0, out_b;
  logic [47:0] in_c = '0, out_c;
  logic [1:0]  wp_a, wp_b;
  logic [2:0]  wp_c;
  logic        cp_a, cp_b, cp_c;

  int n_chk = 0, n_fail = 0;

  always #5 bus_clk = ~bus_clk;

  bus_split_bank #(.DATAWIDTH(8), .OFFSET(8), .NCHAN(2), .ADDR(32'h40), .IZ(32'h5A),
                   .ATOMIC_RD(0), .ATOMIC_WR(0)) u_a (
    .bus_clk(bus_clk), .bus_reset(bus_reset), .bus_in(bus_in), .bus_out(bo_a),
    .in(in_a), .out(out_a), .wr_pulse(wp_a), .commit_pulse(cp_a));

  bus_split_bank #(.DATAWIDTH(32), .OFFSET(0), .NCHAN(2), .ADDR(32'h80), .IZ(32'h0),
                   .ATOMIC_RD(1), .ATOMIC_WR(0)) u_b (
    .bus_clk(bus_clk), .bus_reset(bus_reset), .bus_in(bus_in), .bus_out(bo_b),
    .in(in_b), .out(out_b), .wr_pulse(wp_b), .commit_pulse(cp_b));

  bus_split_bank #(.DATAWIDTH(16), .OFFSET(4), .NCHAN(3), .ADDR(32'h100), .IZ(32'h5A),
                   .ATOMIC_RD(1), .ATOMIC_WR(1)) u_c (
    .bus_clk(bus_clk), .bus_reset(bus_reset), .bus_in(bus_in), .bus_out(bo_c),
    .in(in_c), .out(out_c), .wr_pulse(wp_c), .commit_pulse(cp_c));

  // reference state
  logic [31:0] m_out  [NI][4];
  logic [31:0] m_stage[NI][4];
  logic [31:0] m_snap [NI][4];
  logic [3:0]  m_pulse[NI];
  bit          m_commit[NI];

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] fmask(input int w);
    return (w >= 32) ? 32'hFFFF_FFFF : ((32'h1 << w) - 32'h1);
  endfunction

  function automatic logic [31:0] get_in(input int i, input int k);
    logic [63:0] v;
    v = (i == 0) ? 64'(in_a) : (i == 1) ? in_b : 64'(in_c);
    return 32'(v >> (k * P_DW[i])) & fmask(P_DW[i]);
  endfunction

  // channel index hit by addr in instance i, or -1
  function automatic int chan_of(input int i, input logic [31:0] a);
    logic [31:0] aw;
    aw = a & ~32'h3;
    if (aw < P_BASE[i] || aw >= P_BASE[i] + 32'(4 * P_N[i])) return -1;
    return int'((aw - P_BASE[i]) >> 2);
  endfunction

  function automatic logic [63:0] exp_out(input int i);
    logic [63:0] v;
    v = '0;
    for (int k = 0; k < P_N[i]; k++)
      v |= 64'(m_out[i][k] & fmask(P_DW[i])) << (k * P_DW[i]);
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < NI; i++) begin
      for (int k = 0; k < 4; k++) begin
        m_out[i][k]   = P_IZ[i] & fmask(P_DW[i]);
        m_stage[i][k] = P_IZ[i] & fmask(P_DW[i]);
        m_snap[i][k]  = '0;
      end
      m_pulse[i]  = '0;
      m_commit[i] = 1'b0;
    end
  endtask

  task automatic model_edge(input bit rst, input bit we, input bit re,
                            input logic [31:0] a, input logic [31:0] wd);
    int k, n;
    logic [31:0] v;
    if (rst) begin
      model_reset();
      return;
    end
    for (int i = 0; i < NI; i++) begin
      k = chan_of(i, a);
      n = P_N[i];
      m_pulse[i]  = '0;
      m_commit[i] = 1'b0;
      if (k < 0) continue;
      if (re && k == 0 && P_ARD[i])
        for (int j = 1; j < n; j++) m_snap[i][j] = get_in(i, j);
      if (we) begin
        v = (wd >> P_OFF[i]) & fmask(P_DW[i]);
        if (!P_AWR[i]) begin
          m_out[i][k]   = v;
          m_pulse[i][k] = 1'b1;
        end else if (k == n - 1) begin
          for (int j = 0; j < n - 1; j++) m_out[i][j] = m_stage[i][j];
          m_out[i][n-1] = v;
          m_pulse[i]    = 4'((1 << n) - 1);
          m_commit[i]   = 1'b1;
        end else begin
          m_stage[i][k] = v;
        end
      end
    end
  endtask

  function automatic logic [34:0] exp_bus(input int i, input bit we, input bit re,
                                          input logic [31:0] a);
    int k;
    logic [31:0] v;
    k = chan_of(i, a);
    if (k < 0) return '0;
    v = (P_ARD[i] && k >= 1) ? m_snap[i][k] : get_in(i, k);
    return {1'b0, we, re, re ? ((v & fmask(P_DW[i])) << P_OFF[i]) : 32'h0};
  endfunction

  // one bus cycle: comb checks mid-cycle, registered checks just after the edge
  task automatic step(input bit rst, input bit we, input bit re,
                      input logic [31:0] a, input logic [31:0] wd);
    bus_reset = rst;
    bus_in    = {we, re, a, wd};
    #1;
    chk("bus_out_a", 64'(bo_a), 64'(exp_bus(0, we, re, a)));
    chk("bus_out_b", 64'(bo_b), 64'(exp_bus(1, we, re, a)));
    chk("bus_out_c", 64'(bo_c), 64'(exp_bus(2, we, re, a)));
    @(posedge bus_clk);
    model_edge(rst, we, re, a, wd);
    #1;
    chk("out_a", 64'(out_a), exp_out(0));
    chk("out_b", out_b, exp_out(1));
    chk("out_c", 64'(out_c), exp_out(2));
    chk("pulse_a", 64'({cp_a, wp_a}), 64'({m_commit[0], m_pulse[0][1:0]}));
    chk("pulse_b", 64'({cp_b, wp_b}), 64'({m_commit[1], m_pulse[1][1:0]}));
    chk("pulse_c", 64'({cp_c, wp_c}), 64'({m_commit[2], m_pulse[2][2:0]}));
    @(negedge bus_clk);
  endtask

  initial begin
    logic [31:0] base, a;
    model_reset();
    @(negedge bus_clk);

    // reset values
    step(1, 0, 0, 32'h0, 32'h0);
    step(1, 0, 0, 32'h0, 32'h0);
    step(0, 0, 0, 32'h0, 32'h0);
    chk("rst_out_a", 64'(out_a), 64'h5A5A);
    chk("rst_out_c", 64'(out_c), 64'h005A_005A_005A);
    step(0, 0, 1, 32'h84, 32'h0);
    chk("rst_snap_b", 64'(bo_b[31:0]), 64'h0);

    // plain split write / read
    step(0, 1, 0, 32'h44, 32'h0000_3400);
    chk("wr_out_a", 64'(out_a), 64'h345A);
    chk("wr_pulse_a", 64'(wp_a), 64'h2);
    step(0, 0, 0, 32'h0, 32'h0);
    chk("wr_pulse_a_off", 64'(wp_a), 64'h0);
    in_a = 16'hC100;
    step(0, 0, 1, 32'h44, 32'h0);
    chk("rd_a", 64'(bo_a[32:0]), 64'h1_0000_C100);
    step(0, 0, 1, 32'h48, 32'h0);
    chk("rd_a_miss", 64'(bo_a), 64'h0);

    // atomic read
    in_b = {32'h1111_1111, 32'h2222_2222};
    step(0, 0, 1, 32'h80, 32'h0);
    in_b[63:32] = 32'h3333_3333;
    step(0, 0, 1, 32'h84, 32'h0);
    chk("snap_old_b", 64'(bo_b[31:0]), 64'h1111_1111);
    step(0, 0, 1, 32'h80, 32'h0);
    step(0, 0, 1, 32'h84, 32'h0);
    chk("snap_new_b", 64'(bo_b[31:0]), 64'h3333_3333);

    // atomic write
    step(0, 1, 0, 32'h100, 32'hA0);
    step(0, 1, 0, 32'h104, 32'hB0);
    chk("stage_out_c", 64'(out_c), 64'h005A_005A_005A);
    step(0, 1, 0, 32'h108, 32'hC0);
    chk("commit_out_c", 64'(out_c), 64'h000C_000B_000A);
    chk("commit_pulse_c", 64'({cp_c, wp_c}), 64'hF);

    // reset mid-sequence discards staged data
    step(0, 1, 0, 32'h100, 32'hA0);
    step(1, 0, 0, 32'h0, 32'h0);
    step(0, 1, 0, 32'h108, 32'hC0);
    chk("midrst_out_c", 64'(out_c), 64'h000C_005A_005A);

    // reset beats a write in the same cycle
    step(1, 1, 0, 32'h40, 32'hFFFF_FFFF);
    chk("rstwr_out_a", 64'(out_a), 64'h5A5A);
    chk("rstwr_pulse_a", 64'(wp_a), 64'h0);

    // random traffic
    for (int n = 0; n < 600; n++) begin
      in_a = 16'($urandom);
      in_b = {$urandom, $urandom};
      in_c = 48'({$urandom, $urandom});
      case ($urandom_range(0, 2))
        0:       base = 32'h40;
        1:       base = 32'h80;
        default: base = 32'h100;
      endcase
      a = base + 32'($urandom_range(0, 3) * 4) + 32'($urandom_range(0, 3));
      if ($urandom_range(0, 9) == 0) a = a - 32'h4;
      step($urandom_range(0, 39) == 0, $urandom_range(0, 1) == 1,
           $urandom_range(0, 1) == 1, a, $urandom);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/bus_split_bank.md
# bus_split_bank

Bank of NCHAN split registers at consecutive word addresses on the local register bus. Each channel returns a hardware input on reads and drives a separately held output on writes. Two optional modes make multi-word values coherent:
- **Read-atomic mode:** a read of channel 0 snapshots all other inputs.
- **Write-atomic mode:** writes are staged and committed together by the write to the last channel.

The block is used wherever a multi-word counter, timestamp or configuration word must cross the 32-bit bus without tearing.

## Interface
Parameters:
- DATAWIDTH, 32: bits per channel (1..32)
- OFFSET, 0: bit position of the field within the bus word (0..32-DATAWIDTH)
- NCHAN, 2: number of channels (1..16)
- ADDR, 0: word-aligned byte address of channel 0; channel k is at ADDR+4k
- IZ, 0: reset value of every channel output and staging register
- ATOMIC_RD, 0: 1 enables snapshot-on-read of channel 0
- ATOMIC_WR, 0: 1 enables staged writes committed by channel NCHAN-1
- REG, 1: flag marking this block as a register
- SIZE, 4*NCHAN: byte span of the block

Ports:
- bus_clk  in  1  the single clock; all state is on its rising edge
- bus_reset  in  1  synchronous, active-high reset
- bus_in  in  BUS_IN_WIDTH  bus request (address, re, we, wr_data) per bus_params.v
- bus_out  out  BUS_OUT_WIDTH  rd_data, rd_ack, wr_ack, irq
- in  in  NCHAN*DATAWIDTH  read sources; channel k occupies bits [k*DATAWIDTH +: DATAWIDTH]
- out  out  NCHAN*DATAWIDTH  written values, same packing as in
- wr_pulse  out  NCHAN  one-cycle strobe per channel when its out is updated
- commit_pulse  out  1  one-cycle strobe on an atomic commit; stays 0 when ATOMIC_WR=0

## Operation
- **Decode:** hit[k] = ({addr[MSB:2],2'b00} == ADDR+4k) for k < NCHAN. Addresses outside the span produce no ack and rd_data 0.
- **Read acknowledge:** rd_ack = any hit & re. rd_data = (selected value << OFFSET), zero-extended; rd_data is 0 when there is no rd_ack.
- **Read source, ATOMIC_RD=0:** live in[k].
- **Read source, ATOMIC_RD=1:**
  - Channel 0 returns live in[0].
  - On the same edge as that read, snap[1..NCHAN-1] <= in[1..NCHAN-1].
  - Reads of k≥1 return snap[k].
  - snap resets to 0.
  - With NCHAN=1, ATOMIC_RD has no effect.
- **Write acknowledge:** wr_ack = any hit & we. The written value is (wr_data >> OFFSET) truncated to DATAWIDTH.
- **Write, ATOMIC_WR=0:** out[k] <= value and wr_pulse[k] <= 1 on the write edge.
- **Write, ATOMIC_WR=1:**
  - Writes to k < NCHAN-1 load stage[k] only. out and wr_pulse do not change.
  - A write to NCHAN-1 commits on that edge: out[k] <= stage[k] for k < NCHAN-1, and out[NCHAN-1] <= value.
  - On the same edge, every wr_pulse bit is set and commit_pulse is set.
  - stage is not cleared by a commit; it resets to IZ.
  - With NCHAN=1 every write is a commit.
- **Simultaneous re and we:** handled independently. A channel-0 read snapshot and a write in the same cycle both take effect.
- **Reset:**
  - out = IZ on every channel; wr_pulse = 0; commit_pulse = 0; snap = 0; stage = IZ.
  - Reset overrides a write or read snapshot in the same cycle.
  - Reset asserted mid-sequence (some channels staged) discards the staged data.
- **irq:** bus_out irq is always 0.

## Timing
- rd_ack, wr_ack and rd_data are combinational from bus_in in the request cycle; there are no wait states.
- out updates on the rising edge that samples we. The new value is visible from the next cycle.
- wr_pulse and commit_pulse are high for exactly the one cycle after that edge, aligned with the new out.
- Back-to-back writes to the same channel produce consecutive pulse cycles, and out follows each write.
- A snapshot taken on edge N is returned by any read of k≥1 from cycle N+1 onward, until the next channel-0 read.
- A read of k≥1 in the same cycle as the channel-0 read cannot occur on this bus (single request per cycle).

## Test plan
- **Reset values:** IZ=0x5A, NCHAN=2; assert bus_reset for 2 cycles -> out=0x005A_005A (DATAWIDTH=16), wr_pulse=00, commit_pulse=0; reads of ADDR+4 return 0 when ATOMIC_RD=1.
- **Plain split write/read:** ATOMIC_*=0, OFFSET=8, DATAWIDTH=8.
  - Write 0x0000_3400 to ADDR+4 -> out[1]=0x34, wr_pulse=10 for one cycle.
  - Drive in[1]=0xC1; read ADDR+4 -> rd_data=0x0000_C100, rd_ack=1.
  - Read ADDR+8 -> no ack, rd_data=0.
- **Atomic read:** NCHAN=2, ATOMIC_RD=1.
  - Set in = {0x1111_1111, 0x2222_2222}; read ADDR -> 0x2222_2222.
  - Change in[1] to 0x3333_3333; read ADDR+4 -> 0x1111_1111.
  - Read ADDR again, then ADDR+4 -> 0x3333_3333.
- **Atomic write:** NCHAN=3, ATOMIC_WR=1.
  - Write 0xA to ADDR and 0xB to ADDR+4 -> out unchanged at IZ, no pulses.
  - Write 0xC to ADDR+8 -> out = {0xC,0xB,0xA}, wr_pulse=111 and commit_pulse=1 for one cycle.
- **Reset mid-sequence:** NCHAN=3, ATOMIC_WR=1, IZ=0.
  - Stage 0xA at ADDR, pulse bus_reset, then write 0xC to ADDR+8 -> out = {0xC,0x0,0x0}.
- **Reset vs write collision:** we to ADDR in the same cycle as bus_reset -> out stays IZ, no wr_pulse.
